// File: rtl/spm_program_loader.sv
// spm_program_loader: streams a length-prefixed program from a host byte
// interface into a 256-byte program memory, then releases the processor reset.
// Stream: length byte L (0 means 256), then L program bytes.
// Optional macro LOADER_CHECKSUM_EN adds a trailing checksum byte. The length
// byte, the program bytes and the checksum byte must sum to 0x00 mod 256, or
// the load ends in the error state.
module spm_program_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd5;
`endif

  logic [2:0]        state;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     fcount;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [7:0]        head;
  logic [8:0]        remaining;
  logic [ADDR_W-1:0] addr;

  assign fifo_full  = (fcount == CW'(FIFO_DEPTH));
  assign fifo_empty = (fcount == '0);
  assign head       = fifo_mem[rptr];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] chk_total;
  assign chk_total = sum + head;
  assign busy = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign err  = (state == ST_ERR);
`else
  assign busy = (state == ST_LEN) || (state == ST_DATA);
  assign err  = 1'b0;
`endif

  assign done     = (state == ST_RUN);
  assign in_ready = busy && !fifo_full;
  // start wins over any transfer on the same edge; the presented byte is lost.
  assign push     = in_valid && in_ready && !start;
  assign pop      = busy && !fifo_empty && !start;

  // Byte storage; validity is tracked by the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= in_data;
  end

  // FIFO pointers and occupancy; start flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else if (start) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      fcount <= fcount + 1'b1;
      else if (pop && !push) fcount <= fcount - 1'b1;
    end
  end

  // Load sequencer, registered memory write port and processor reset hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      addr       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      byte_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we    <= 1'b0;
      // Registered from the state so release lands one cycle after the last write.
      cpu_rst_n <= (state == ST_RUN) && !start;
      if (start) begin
        state      <= ST_LEN;
        byte_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end else if (pop) begin
        case (state)
          ST_LEN: begin
            remaining  <= (head == 8'h00) ? 9'd256 : {1'b0, head};
            addr       <= '0;
            byte_count <= '0;
            state      <= ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            sum        <= head;
`endif
          end
          ST_DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= addr;
            mem_wdata  <= head;
            addr       <= addr + 1'b1;
            byte_count <= byte_count + 1'b1;
            remaining  <= remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum        <= sum + head;
            if (remaining == 9'd1) state <= ST_CHK;
`else
            if (remaining == 9'd1) state <= ST_RUN;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHK: begin
            sum   <= chk_total;
            state <= (chk_total == 8'h00) ? ST_RUN : ST_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spm_program_loader.sv
// Scoreboard bench for spm_program_loader: expected memory writes are queued
// as bytes are offered, and a negedge monitor checks each mem_we cycle.
module tb_spm_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] byte_count;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];
  logic [7:0]  csum;

  spm_program_loader #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        check("write", {16'h0, mem_addr, mem_wdata}, {16'h0, sb.pop_front()});
      end
    end
  end

  // Offer one byte (called at a negedge); returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input bit exp, input logic [7:0] a);
    bit ok = 1'b0;
    if (exp) sb.push_back({a, b});
    csum     = csum + b;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    check("accept", {31'h0, ok}, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
    send(8'h00 - csum, 1'b0, 8'h00);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    csum  = 8'h00;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", {31'h0, done}, 32'h1);
    check("cpu_rst_n_held_in_first_run_cycle", {31'h0, cpu_rst_n}, 32'h0);
    @(negedge clk);
    check("cpu_rst_n_released", {31'h0, cpu_rst_n}, 32'h1);
  endtask

  initial begin
    csum = 8'h00;
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr_data", {16'h0, mem_addr, mem_wdata}, 32'h0);
    check("rst_flags", {28'h0, cpu_rst_n, busy, done, err}, 32'h0);
    check("rst_byte_count", {23'h0, byte_count}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores the host.
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge clk);
    check("idle_in_ready", {31'h0, in_ready}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
    in_valid = 1'b0;

    // Basic three-byte load.
    pulse_start();
    check("len_busy", {31'h0, busy}, 32'h1);
    check("len_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
    send(8'h03, 1'b0, 8'h00);
    send(8'h11, 1'b1, 8'h00);
    send(8'h22, 1'b1, 8'h01);
    send(8'h33, 1'b1, 8'h02);
    send_chk();
    wait_done();
    check("t1_byte_count", {23'h0, byte_count}, 32'd3);
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(negedge clk);
    check("run_in_ready", {31'h0, in_ready}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_no_pending", sb.size(), 32'd0);

    // Length 0 means 256 bytes; streamed back to back with in_valid held high.
    pulse_start();
    send(8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, 1'b1, 8'(i));
    send_chk();
    wait_done();
    check("t2_byte_count", {23'h0, byte_count}, 32'd256);
    repeat (2) @(negedge clk);
    check("t2_no_pending", sb.size(), 32'd0);

    // Restart after two bytes of a five-byte load.
    pulse_start();
    send(8'h05, 1'b0, 8'h00);
    send(8'hA0, 1'b1, 8'h00);
    send(8'hB1, 1'b1, 8'h01);
    repeat (4) @(negedge clk);
    check("t3_partial_count", {23'h0, byte_count}, 32'd2);
    pulse_start();
    check("t3_restart_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
    check("t3_restart_count", {23'h0, byte_count}, 32'd0);
    send(8'h01, 1'b0, 8'h00);
    send(8'hAA, 1'b1, 8'h00);
    check("t3_cpu_rst_n_before_done", {31'h0, cpu_rst_n}, 32'h0);
    send_chk();
    wait_done();
    check("t3_byte_count", {23'h0, byte_count}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h02, 1'b0, 8'h00);
    send(8'h10, 1'b1, 8'h00);
    send(8'h20, 1'b1, 8'h01);
    send(8'hCE, 1'b0, 8'h00);
    wait_done();
    pulse_start();
    send(8'h02, 1'b0, 8'h00);
    send(8'h10, 1'b1, 8'h00);
    send(8'h20, 1'b1, 8'h01);
    send(8'hCF, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("chk_err", {31'h0, err}, 32'h1);
    check("chk_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
    check("chk_in_ready", {31'h0, in_ready}, 32'h0);
    check("chk_done", {31'h0, done}, 32'h0);
`endif

    // Asynchronous reset in the middle of DATA; third byte never gets written.
    pulse_start();
    send(8'h08, 1'b0, 8'h00);
    send(8'h01, 1'b1, 8'h00);
    send(8'h02, 1'b1, 8'h01);
    send(8'h03, 1'b0, 8'h02);
    #2 rst = 1'b0;
    #1;
    check("async_in_ready", {31'h0, in_ready}, 32'h0);
    check("async_mem_we", {31'h0, mem_we}, 32'h0);
    check("async_addr_data", {16'h0, mem_addr, mem_wdata}, 32'h0);
    check("async_flags", {28'h0, cpu_rst_n, busy, done, err}, 32'h0);
    check("async_byte_count", {23'h0, byte_count}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    send(8'h02, 1'b0, 8'h00);
    send(8'h5A, 1'b1, 8'h00);
    send(8'hA5, 1'b1, 8'h01);
    send_chk();
    wait_done();
    check("t6_byte_count", {23'h0, byte_count}, 32'd2);

    repeat (3) @(negedge clk);
    check("final_no_pending", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
